// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus for regfile_wb_ctrl: two write-back requesters in, one RF write port out.
// The master side drives requests and observes ready and the RF strobe; the slave side is the controller.
interface regfile_wb_ctrl_if #(
  parameter int XLEN = 64
);
  logic            wb0_valid;
  logic            wb0_ready;
  logic [4:0]      wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic            wb1_valid;
  logic            wb1_ready;
  logic [4:0]      wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic            rf_w_en;
  logic [4:0]      rf_rd_index;
  logic [XLEN-1:0] rf_rd_data;

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  wb0_ready, wb1_ready, rf_w_en, rf_rd_index, rf_rd_data
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output wb0_ready, wb1_ready, rf_w_en, rf_rd_index, rf_rd_data
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter (ALU vs LSU, round-robin under contention) plus the per-register busy scoreboard.
// Optional RF_WB_FWD_EN adds same-cycle forwarding of the RF write payload to the source queries.
module regfile_wb_ctrl #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  regfile_wb_ctrl_if.slave wb,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_waw,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef RF_WB_FWD_EN
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] fwd_data,
`endif
  input  logic            flush
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  wb_req_t         req0, req1, win;
  logic            gnt0, gnt1, any_gnt;
  logic            rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_w_en_q, rf_w_en_d;
  logic [4:0]      rf_rd_index_q, rf_rd_index_d;
  logic [XLEN-1:0] rf_rd_data_q, rf_rd_data_d;

  always_comb begin
    req0.rd   = wb.wb0_rd;
    req0.data = wb.wb0_data;
    req1.rd   = wb.wb1_rd;
    req1.data = wb.wb1_data;
    // Grants are masked by reset so ready reads 0 while held in reset.
    gnt0    = rst && wb.wb0_valid && (!wb.wb1_valid || !rr_ptr_q);
    gnt1    = rst && wb.wb1_valid && (!wb.wb0_valid ||  rr_ptr_q);
    any_gnt = gnt0 || gnt1;
    win     = gnt1 ? req1 : req0;

    rr_ptr_d = rr_ptr_q;
    if (wb.wb0_valid && wb.wb1_valid) rr_ptr_d = !gnt1;

    rf_w_en_d     = any_gnt && (win.rd != 5'd0);
    rf_rd_index_d = any_gnt ? win.rd   : rf_rd_index_q;
    rf_rd_data_d  = any_gnt ? win.data : rf_rd_data_q;

    // Clear, then flush, then set: a same-cycle issue survives both.
    busy_d = busy_q;
    if (rf_w_en_q) busy_d[rf_rd_index_q] = 1'b0;
    if (flush) busy_d = '0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= 1'b0;
      busy_q        <= '0;
      rf_w_en_q     <= 1'b0;
      rf_rd_index_q <= '0;
      rf_rd_data_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      rf_w_en_q     <= rf_w_en_d;
      rf_rd_index_q <= rf_rd_index_d;
      rf_rd_data_q  <= rf_rd_data_d;
    end
  end

  assign wb.wb0_ready   = gnt0;
  assign wb.wb1_ready   = gnt1;
  assign wb.rf_w_en     = rf_w_en_q;
  assign wb.rf_rd_index = rf_rd_index_q;
  assign wb.rf_rd_data  = rf_rd_data_q;
  assign issue_waw      = busy_q[issue_rd];

`ifdef RF_WB_FWD_EN
  assign rs1_fwd  = rf_w_en_q && (rf_rd_index_q == q_rs1) && (q_rs1 != 5'd0);
  assign rs2_fwd  = rf_w_en_q && (rf_rd_index_q == q_rs2) && (q_rs2 != 5'd0);
  assign fwd_data = rf_rd_data_q;
  assign rs1_busy = busy_q[q_rs1] && !rs1_fwd;
  assign rs2_busy = busy_q[q_rs2] && !rs2_fwd;
`else
  // The bit is still set during the write cycle since the RF has not captured yet.
  assign rs1_busy = busy_q[q_rs1];
  assign rs2_busy = busy_q[q_rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed test-plan sequences followed by random traffic.
module tb_regfile_wb_ctrl;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.XLEN(XLEN)) wbif ();
  logic            issue_valid, issue_waw, rs1_busy, rs2_busy, flush;
  logic [4:0]      issue_rd, q_rs1, q_rs2;
`ifdef RF_WB_FWD_EN
  logic            rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] fwd_data;
`endif

  regfile_wb_ctrl #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst), .wb(wbif),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_waw(issue_waw),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef RF_WB_FWD_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data),
`endif
    .flush(flush)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Reference state: set of busy registers, whose turn it is under contention,
  // and the write expected on the RF port in the current cycle.
  bit [31:0]       m_busy;
  bit              m_turn_lsu;
  bit              m_wen;
  logic [4:0]      m_widx;
  logic [XLEN-1:0] m_wdata;
  bit              m_g0, m_g1;

  function automatic void chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every RF write strobe must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && wbif.rf_w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rf_unexpected_write idx=%0d data=%h", wbif.rf_rd_index, wbif.rf_rd_data);
        end else begin
          w = exp_q.pop_front();
          chk("rf_rd_index", {59'd0, wbif.rf_rd_index}, {59'd0, w.rd});
          chk("rf_rd_data", wbif.rf_rd_data, w.data);
        end
      end
    end
  end

  task automatic idle();
    wbif.wb0_valid = 1'b0; wbif.wb1_valid = 1'b0;
    issue_valid = 1'b0; flush = 1'b0;
    q_rs1 = 5'd0; q_rs2 = 5'd0; issue_rd = 5'd0;
  endtask

  // Inputs are applied just after a rising edge; step checks combinational outputs at the
  // falling edge against the model, advances the model, and returns just after the next rise.
  task automatic step();
    bit g0, g1;
    bit [31:0] nb;
    @(negedge clk);
    g0 = wbif.wb0_valid && (!wbif.wb1_valid || !m_turn_lsu);
    g1 = wbif.wb1_valid && !g0;
    chk("wb0_ready", {63'd0, wbif.wb0_ready}, {63'd0, g0});
    chk("wb1_ready", {63'd0, wbif.wb1_ready}, {63'd0, g1});
    chk("issue_waw", {63'd0, issue_waw}, {63'd0, m_busy[issue_rd]});
`ifdef RF_WB_FWD_EN
    begin
      bit f1, f2;
      f1 = m_wen && m_widx == q_rs1 && q_rs1 != 0;
      f2 = m_wen && m_widx == q_rs2 && q_rs2 != 0;
      chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, m_busy[q_rs1] && !f1});
      chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, m_busy[q_rs2] && !f2});
      chk("rs1_fwd", {63'd0, rs1_fwd}, {63'd0, f1});
      chk("rs2_fwd", {63'd0, rs2_fwd}, {63'd0, f2});
      if (f1 || f2) chk("fwd_data", fwd_data, m_wdata);
    end
`else
    chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, m_busy[q_rs1]});
    chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, m_busy[q_rs2]});
`endif
    nb = m_busy;
    if (m_wen) nb[m_widx] = 1'b0;
    if (flush) nb = '0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    if (wbif.wb0_valid && wbif.wb1_valid) m_turn_lsu = g0;
    m_wen = 1'b0;
    if (g0 && wbif.wb0_rd != 0) begin m_wen = 1'b1; m_widx = wbif.wb0_rd; m_wdata = wbif.wb0_data; end
    if (g1 && wbif.wb1_rd != 0) begin m_wen = 1'b1; m_widx = wbif.wb1_rd; m_wdata = wbif.wb1_data; end
    if (m_wen) exp_q.push_back('{m_widx, m_wdata});
    m_g0 = g0; m_g1 = g1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wbif.wb0_rd = 5'd3; wbif.wb0_data = '0; wbif.wb1_rd = 5'd4; wbif.wb1_data = '0;
    #1 rst = 1'b0;
    wbif.wb0_valid = 1'b1; wbif.wb1_valid = 1'b1; issue_rd = 5'd5;
    #11;
    chk("reset_wb0_ready", {63'd0, wbif.wb0_ready}, 64'd0);
    chk("reset_wb1_ready", {63'd0, wbif.wb1_ready}, 64'd0);
    chk("reset_rf_w_en", {63'd0, wbif.rf_w_en}, 64'd0);
    chk("reset_rf_rd_index", {59'd0, wbif.rf_rd_index}, 64'd0);
    chk("reset_rf_rd_data", wbif.rf_rd_data, 64'd0);
    chk("reset_issue_waw", {63'd0, issue_waw}, 64'd0);
    idle();
    @(posedge clk); #1 rst = 1'b1;
    m_busy = '0; m_turn_lsu = 1'b0; m_wen = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;

    // Issue rd 5, then observe WAW and RAW on it.
    issue_valid = 1'b1; issue_rd = 5'd5; step();
    idle(); issue_rd = 5'd5; q_rs1 = 5'd5; step();

    // Single ALU write-back clearing rd 5.
    idle(); wbif.wb0_valid = 1'b1; wbif.wb0_rd = 5'd5; wbif.wb0_data = 64'hDEADBEEF; q_rs1 = 5'd5; step();
    idle(); q_rs1 = 5'd5; step();
    idle(); q_rs1 = 5'd5; step();

    // Four cycles of contention; the granted side presents a fresh payload.
    idle();
    wbif.wb0_valid = 1'b1; wbif.wb0_rd = 5'd10; wbif.wb0_data = 64'hA0;
    wbif.wb1_valid = 1'b1; wbif.wb1_rd = 5'd11; wbif.wb1_data = 64'hB0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (m_g0) begin wbif.wb0_rd = 5'(12 + k); wbif.wb0_data = 64'(16'hA1 + k); end
      if (m_g1) begin wbif.wb1_rd = 5'(20 + k); wbif.wb1_data = 64'(16'hB1 + k); end
    end
    idle(); step(); step();

    // rd 0 write-back: accepted, no strobe.
    wbif.wb1_valid = 1'b1; wbif.wb1_rd = 5'd0; wbif.wb1_data = 64'h1234; step();
    idle(); step(); step();

    // Same-cycle set and clear on rd 7.
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    idle(); wbif.wb0_valid = 1'b1; wbif.wb0_rd = 5'd7; wbif.wb0_data = 64'h77; step();
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; q_rs1 = 5'd7; step();
    idle(); q_rs1 = 5'd7; step();

    // Flush clears busy 3 and 9.
    issue_valid = 1'b1; issue_rd = 5'd3; step();
    issue_rd = 5'd9; step();
    idle(); flush = 1'b1; q_rs1 = 5'd3; q_rs2 = 5'd9; step();
    idle(); q_rs1 = 5'd3; q_rs2 = 5'd9; step();

    // Query during the write cycle of rd 9 (forwarding case when enabled).
    issue_valid = 1'b1; issue_rd = 5'd9; step();
    idle(); wbif.wb1_valid = 1'b1; wbif.wb1_rd = 5'd9; wbif.wb1_data = 64'h55; step();
    idle(); q_rs2 = 5'd9; step();
    idle(); q_rs2 = 5'd9; step();

    // Random traffic; a stalled requester holds its payload.
    for (int i = 0; i < 3000; i++) begin
      if (!(wbif.wb0_valid && !m_g0)) begin
        wbif.wb0_valid = ($urandom % 3) != 0;
        wbif.wb0_rd = 5'($urandom); wbif.wb0_data = {$urandom, $urandom};
      end
      if (!(wbif.wb1_valid && !m_g1)) begin
        wbif.wb1_valid = ($urandom % 3) != 0;
        wbif.wb1_rd = 5'($urandom); wbif.wb1_data = {$urandom, $urandom};
      end
      issue_valid = ($urandom % 2) != 0;
      issue_rd = 5'($urandom);
      q_rs1 = ($urandom % 2) ? m_widx : 5'($urandom);
      q_rs2 = ($urandom % 2) ? m_widx : 5'($urandom);
      flush = ($urandom % 40) == 0;
      step();
    end
    idle(); step(); step(); step();
    chk("expected_writes_drained", 64'(exp_q.size()), 64'd0);

    // Reset during a pending RF write drops it immediately.
    wbif.wb0_valid = 1'b1; wbif.wb0_rd = 5'd4; wbif.wb0_data = 64'hCAFE;
    issue_valid = 1'b1; issue_rd = 5'd4; step();
    chk("pre_reset_rf_w_en", {63'd0, wbif.rf_w_en}, 64'd1);
    idle(); issue_rd = 5'd4;
    rst = 1'b0; #1;
    chk("midreset_rf_w_en", {63'd0, wbif.rf_w_en}, 64'd0);
    chk("midreset_rf_rd_index", {59'd0, wbif.rf_rd_index}, 64'd0);
    chk("midreset_rf_rd_data", wbif.rf_rd_data, 64'd0);
    chk("midreset_issue_waw", {63'd0, issue_waw}, 64'd0);
    exp_q.delete();
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
